// File: rtl/mem_ctrl.sv
// mem_ctrl -- byte-serial memory controller arbitrating an instruction-fetch
// port and a load/store port onto a single 8-bit RAM.
//
// Ports:
//   clk, rst         system clock; asynchronous active-high reset
//   if_req/if_addr   fetch request (always 4 bytes) and byte address
//   if_cancel        abandons a pending or in-flight fetch
//   if_done/if_data  one-cycle completion pulse and little-endian fetched word
//   mem_req/mem_we   load/store request, 1 = store
//   mem_len          00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   mem_addr         load/store byte address
//   mem_wdata        store data, byte i in bits [8i+7:8i]
//   mem_done         one-cycle completion pulse
//   mem_rdata        load data, zero-extended above the transferred bytes
//   ram_a/ram_wr     registered RAM byte address and write strobe
//   ram_dout         registered RAM write data
//   ram_din          RAM read data, valid one cycle after ram_a
//   busy             high whenever the controller is not idle
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [2:0]  nbytes, nbytes_n;
    logic [31:0] wbuf, wbuf_n;
    logic [31:0] rbuf, rbuf_n;
    logic [31:0] rbuf_cap;
    logic [1:0]  rd_idx;
    logic [1:0]  wr_idx;

    logic [31:0] ram_a_n;
    logic        ram_wr_n;
    logic [7:0]  ram_dout_n;
    logic        if_done_n;
    logic        mem_done_n;
    logic [31:0] if_data_n;
    logic [31:0] mem_rdata_n;

    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            2'b00:   len_to_bytes = 3'd1;
            2'b01:   len_to_bytes = 3'd2;
            default: len_to_bytes = 3'd4;
        endcase
    endfunction

    assign busy = (state != IDLE);

    // cnt = (cycle index within the transaction) - 1. In read states the
    // byte presented on ram_din during count c belongs to byte c-1, so
    // rbuf_cap merges it in; on the last count the merged word goes
    // straight to the output register alongside the done pulse.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        nbytes_n    = nbytes;
        wbuf_n      = wbuf;
        rbuf_n      = rbuf;
        ram_a_n     = ram_a;
        ram_wr_n    = 1'b0;
        ram_dout_n  = ram_dout;
        if_done_n   = 1'b0;
        mem_done_n  = 1'b0;
        if_data_n   = if_data;
        mem_rdata_n = mem_rdata;

        rd_idx   = cnt[1:0] - 2'd1;
        wr_idx   = cnt[1:0] + 2'd1;
        rbuf_cap = rbuf;
        rbuf_cap[{rd_idx, 3'b000} +: 8] = ram_din;

        case (state)
            IDLE: begin
                if (mem_req && !mem_done) begin
                    ram_a_n  = mem_addr;
                    cnt_n    = 3'd0;
                    nbytes_n = len_to_bytes(mem_len);
                    if (mem_we) begin
                        state_n    = MEM_WR;
                        wbuf_n     = mem_wdata;
                        ram_dout_n = mem_wdata[7:0];
                        ram_wr_n   = 1'b1;
                    end else begin
                        state_n = MEM_RD;
                        rbuf_n  = '0;
                    end
                end else if (if_req && !if_done && !if_cancel) begin
                    state_n  = IF_RD;
                    ram_a_n  = if_addr;
                    cnt_n    = 3'd0;
                    nbytes_n = 3'd4;
                    rbuf_n   = '0;
                end
            end

            IF_RD, MEM_RD: begin
                if (state == IF_RD && if_cancel) begin
                    // Flush: drop partial data, no done pulse.
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    if (cnt < nbytes - 3'd1) begin
                        ram_a_n = ram_a + 32'd1;
                    end
                    if (cnt != 3'd0) begin
                        rbuf_n = rbuf_cap;
                    end
                    if (cnt == nbytes) begin
                        state_n = IDLE;
                        cnt_n   = 3'd0;
                        if (state == IF_RD) begin
                            if_done_n = 1'b1;
                            if_data_n = rbuf_cap;
                        end else begin
                            mem_done_n  = 1'b1;
                            mem_rdata_n = rbuf_cap;
                        end
                    end else begin
                        cnt_n = cnt + 3'd1;
                    end
                end
            end

            MEM_WR: begin
                if (cnt < nbytes - 3'd1) begin
                    ram_a_n    = ram_a + 32'd1;
                    ram_dout_n = wbuf[{wr_idx, 3'b000} +: 8];
                    ram_wr_n   = 1'b1;
                    cnt_n      = cnt + 3'd1;
                end else begin
                    state_n    = IDLE;
                    cnt_n      = 3'd0;
                    mem_done_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nbytes    <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            nbytes    <= nbytes_n;
            wbuf      <= wbuf_n;
            rbuf      <= rbuf_n;
            ram_a     <= ram_a_n;
            ram_wr    <= ram_wr_n;
            ram_dout  <= ram_dout_n;
            if_done   <= if_done_n;
            mem_done  <= mem_done_n;
            if_data   <= if_data_n;
            mem_rdata <= mem_rdata_n;
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on posedge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 if_req  in  1  instruction-fetch request, held until if_done or if_cancel.
REQ-004 if_addr  in  32  fetch byte address, stable while if_req high.
REQ-005 if_cancel  in  1  abandon in-flight or pending fetch (branch flush).
REQ-006 if_done  out  1  one-cycle pulse; if_data valid.
REQ-007 if_data  out  32  fetched word, little-endian.
REQ-008 mem_req  in  1  load/store request, held until mem_done.
REQ-009 mem_we  in  1  1=store, 0=load; stable while mem_req high.
REQ-010 mem_len  in  2  00=1 byte, 01=2 bytes, 10/11=4 bytes.
REQ-011 mem_addr  in  32  load/store byte address.
REQ-012 mem_wdata  in  32  store data; byte i = bits [8i+7:8i].
REQ-013 mem_done  out  1  one-cycle pulse; mem_rdata valid for loads.
REQ-014 mem_rdata  out  32  load data, zero-extended above len bytes.
REQ-015 ram_a  out  32  RAM byte address.
REQ-016 ram_wr  out  1  RAM write strobe.
REQ-017 ram_dout  out  8  RAM write data.
REQ-018 ram_din  in  8  RAM read data, valid one cycle after address.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, IF_RD, MEM_RD, MEM_WR; byte counter cnt 0..N (N = byte count).
REQ-021 Cycle 0 = IDLE cycle with an accepted request; mem_req has priority over if_req in the same cycle.
REQ-022 A requester's req is not accepted in a cycle where its own done is high.
REQ-023 if_req is not accepted in a cycle where if_cancel is high.
REQ-024 Reads (IF_RD, MEM_RD): ram_a = addr+i with ram_wr=0 in cycle 1+i, i = 0..N-1; ram_din captured into byte i at end of cycle 2+i.
REQ-025 Read done pulses in cycle N+2; FSM is IDLE in cycle N+2 and may accept the other requester there.
REQ-026 Writes (MEM_WR): ram_a = addr+i, ram_dout = wdata byte i, ram_wr=1 in cycles 1..N; mem_done pulses in cycle N+1; IDLE in cycle N+1.
REQ-027 ram_wr = 0 in every cycle not listed in REQ-026.
REQ-028 Outputs ram_a, ram_wr, ram_dout, if_done, mem_done are registered.
REQ-029 Address increment wraps modulo 2^32 (0xFFFFFFFF+1 = 0).
REQ-030 if_cancel high in IF_RD: next cycle IDLE, no if_done, partial data discarded; cancelled in-flight fetch is not restarted.
REQ-031 if_cancel has no effect in MEM_RD/MEM_WR; stores are never aborted.
REQ-032 if_data/mem_rdata hold their last value until the next done for that port.
REQ-033 Request arriving mid-transaction waits; accepted in the first IDLE cycle per REQ-021..023.

Reset
REQ-034 On rst: state IDLE, cnt 0, ram_a 0, ram_wr 0, ram_dout 0, if_done 0, mem_done 0, if_data 0, mem_rdata 0, busy 0.
REQ-035 rst mid-transaction aborts immediately; no done pulse; no further ram_wr after rst asserts.
REQ-036 First request accepted in the first cycle after rst deasserts.

Verification
REQ-037 if_req, addr 0x100, RAM bytes 13,00,00,93 -> ram_a 0x100..0x103 cycles 1..4, if_done cycle 6, if_data 0x93000013.
REQ-038 mem_req store len=10, addr 0x20, wdata 0xDEADBEEF -> ram_wr cycles 1..4, ram_dout EF,BE,AD,DE, mem_done cycle 5.
REQ-039 if_req and mem_req (load len=00, addr 0x30, byte 0x80) same cycle -> load first, mem_rdata 0x00000080 cycle 3; fetch accepted cycle 3, if_done cycle 9.
REQ-040 Fetch addr 0xFFFFFFFE -> ram_a FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-041 if_cancel in cycle 2 of fetch -> IDLE cycle 3, no if_done; new if_req at 0x200 completes normally.
REQ-042 rst asserted in cycle 2 of a store -> ram_wr 0 immediately, no mem_done, all outputs at REQ-034 values.
